vga_text_engine: RTL
====================

# vga_text_engine

Parametrised text-mode VGA engine that turns a CPU-writable character buffer into pixel, sync and blank signals for the board DAC. It generalises the fixed 41-character display path: configurable screen timing, text grid, glyph size and colours, plus a self-clearing buffer, a blinking cursor and a frame-start strobe. It sits between the CPU data-memory write port and the VGA pins, with the glyph ROM attached externally.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal porch and sync widths in pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical porch and sync widths in lines
- CHAR_W / CHAR_H, 8 / 16: glyph cell size in pixels; COLS = H_ACTIVE/CHAR_W, ROWS = V_ACTIVE/CHAR_H, ADDR_W = clog2(COLS*ROWS)
- CODE_W, 8: character code width
- FG / BG, 24'hFFFFFF / 24'h000000: foreground/background RGB
- CLEAR_CODE, 8'h20: code written to every cell after reset
- BLINK_FRAMES, 30: frames per cursor blink phase
- clock_25  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  buffer write strobe
- wr_addr  in  ADDR_W  cell index, row*COLS+col
- wr_data  in  CODE_W  character code
- cursor_en  in  1  cursor display enable
- cursor_addr  in  ADDR_W  cursor cell index
- glyph_addr  out  CODE_W+clog2(CHAR_H)  {code, glyph row} to font ROM
- glyph_data  in  CHAR_W  glyph row, MSB = leftmost pixel, valid exactly 1 cycle after glyph_addr
- busy  out  1  high while clearing
- red_out / green_out / blue_out  out  8 each  pixel colour
- hsync / vsync  out  1  active-low syncs
- n_blank  out  1  high during visible pixels
- frame_start  out  1  one-cycle pulse with first visible output pixel of each frame

## Operation
- FSM: CLEAR -> RUN. Reset forces CLEAR, clear address 0. CLEAR writes CLEAR_CODE to one cell per cycle; after cell COLS*ROWS-1, next state RUN. CLEAR lasts exactly COLS*ROWS cycles. Reset mid-clear or mid-frame restarts CLEAR at address 0.
- In CLEAR: wr_en ignored; timing counters held at 0; busy=1; outputs held at reset values.
- In RUN: hcount 0..H_TOTAL-1, wraps to 0 and increments vcount; vcount wraps 0 after V_TOTAL-1. Active when hcount<H_ACTIVE and vcount<V_ACTIVE. hsync low for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on vcount.
- Buffer: single-clock dual-port RAM, 1-cycle read latency, read-first on same-address collision. wr_en with wr_addr >= COLS*ROWS is dropped.
- Pixel pipeline: S0 counters; S1 buffer read at (vcount/CHAR_H)*COLS + hcount/CHAR_W; S2 glyph_addr = {code, vcount%CHAR_H} registered; S3 glyph_data sampled; S4 bit CHAR_W-1-(hcount%CHAR_W) selects FG/BG, registered to outputs. Sync, blank and cell index are delayed alongside.
- Cursor: blink phase starts visible; toggles after every BLINK_FRAMES complete frames. When cursor_en, phase visible and cell == cursor_addr, the pixel bit is inverted. cursor_addr out of range never matches.
- Outside active area: RGB = 0, n_blank = 0 regardless of glyph.

## Timing
- Reset values: rgb 0, hsync 1, vsync 1, n_blank 0, frame_start 0, busy 1, glyph_addr 0, blink phase visible.
- Latency: counter state at cycle t appears on rgb/hsync/vsync/n_blank at t+4; all five aligned.
- First RUN cycle has counters (0,0); frame_start pulses 4 cycles later and every H_TOTAL*V_TOTAL cycles after.
- Write at cycle t is visible to an S1 read at t+1; earlier in-flight pixels show old data.
- Default H_TOTAL = 800, V_TOTAL = 525, frame = 420000 cycles.

## Test plan
- Reset, hold 0: busy high exactly 2400 cycles; RAM dump shows 0x20 in all cells; outputs at reset values throughout.
- Write 0x41 to cell 0, glyph model returns 8'b10000001 for every row: first line pixels 0 and 7 = FFFFFF, pixels 1-6 = 000000, n_blank 1 for pixels 0-639.
- Count one frame: hsync low 96 cycles starting pixel 656; vsync low 2 lines starting line 490; frame_start period 420000.
- cursor_en=1, cursor_addr=81, glyph all zero: cell (row1,col1) white for frames 0-29, black 30-59, white from 60.
- Write at wr_addr 2400 then read all cells: no change; write during CLEAR: ignored.
- Assert reset mid-frame at line 200: outputs return to reset values next cycle; busy re-asserts for 2400 cycles; frame_start restarts aligned.

Source files
------------

// File: rtl/vga_text_engine.sv
// Text-mode VGA engine: clears a character buffer after reset, then scans it through
// an external glyph ROM and drives RGB, syncs, blank and a frame-start strobe.
module vga_text_engine #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter int CHAR_W = 8,
    parameter int CHAR_H = 16,
    parameter int CODE_W = 8,
    parameter logic [23:0] FG = 24'hFFFFFF,
    parameter logic [23:0] BG = 24'h000000,
    parameter logic [CODE_W-1:0] CLEAR_CODE = 8'h20,
    parameter int BLINK_FRAMES = 30,
    localparam int COLS = H_ACTIVE / CHAR_W,
    localparam int ROWS = V_ACTIVE / CHAR_H,
    localparam int CELLS = COLS * ROWS,
    localparam int ADDR_W = $clog2(CELLS),
    localparam int GR_W = $clog2(CHAR_H)
) (
    input  logic                   clock_25,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [CODE_W-1:0]      wr_data,
    input  logic                   cursor_en,
    input  logic [ADDR_W-1:0]      cursor_addr,
    output logic [CODE_W+GR_W-1:0] glyph_addr,
    input  logic [CHAR_W-1:0]      glyph_data,
    output logic                   busy,
    output logic [7:0]             red_out,
    output logic [7:0]             green_out,
    output logic [7:0]             blue_out,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   n_blank,
    output logic                   frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W = $clog2(H_TOTAL);
    localparam int VC_W = $clog2(V_TOTAL);
    localparam int CW_W = $clog2(CHAR_W);
    localparam int BC_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [CODE_W-1:0]  ram_wdata;
    logic [CODE_W-1:0]  mem [CELLS];

    logic [HC_W-1:0]    hcount_p0;
    logic [VC_W-1:0]    vcount_p0;
    int                 h_i, v_i;
    logic               run_p0, vld_p0, hs_p0, vs_p0, fs_p0, frame_end;
    logic [ADDR_W-1:0]  cell_p0;
    logic [GR_W-1:0]    grow_p0;
    logic [CW_W-1:0]    col_p0;

    logic               run_p1, vld_p1, hs_p1, vs_p1, fs_p1;
    logic [CODE_W-1:0]  code_p1;
    logic [GR_W-1:0]    grow_p1;
    logic [CW_W-1:0]    col_p1, col_p2, col_p3;
    logic [ADDR_W-1:0]  cell_p1, cell_p2, cell_p3;
    logic               vld_p2, hs_p2, vs_p2, fs_p2;
    logic               vld_p3, hs_p3, vs_p3, fs_p3;
    logic               cur_hit_p3, pix_p3;
    logic [23:0]        rgb_p3;

    logic               blink_vis;
    logic [BC_W-1:0]    blink_cnt;

    function automatic logic [23:0] shade(input logic active, input logic lit);
        if (!active)
            return 24'h000000;
        return lit ? FG : BG;
    endfunction

    always_ff @(posedge clock_25) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        ram_we     = 1'b0;
        ram_waddr  = wr_addr;
        ram_wdata  = wr_data;
        case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr_q;
                ram_wdata = CLEAR_CODE;
                if (clr_addr_q == ADDR_W'(CELLS - 1))
                    state_d = RUN;
                else
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
            end
            RUN: ram_we = wr_en && (int'(wr_addr) < CELLS);
            default: state_d = CLEAR;
        endcase
    end

    assign busy = (state_q == CLEAR);

    // Stage 0: raster counters and per-pixel decode
    assign h_i = int'(hcount_p0);
    assign v_i = int'(vcount_p0);

    always_ff @(posedge clock_25) begin
        if (reset || state_q != RUN) begin
            hcount_p0 <= '0;
            vcount_p0 <= '0;
        end else if (h_i == H_TOTAL - 1) begin
            hcount_p0 <= '0;
            vcount_p0 <= (v_i == V_TOTAL - 1) ? '0 : vcount_p0 + VC_W'(1);
        end else begin
            hcount_p0 <= hcount_p0 + HC_W'(1);
        end
    end

    assign run_p0    = (state_q == RUN);
    assign vld_p0    = run_p0 && (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
    assign hs_p0     = !(run_p0 && (h_i >= H_ACTIVE + H_FP) && (h_i < H_ACTIVE + H_FP + H_SYNC));
    assign vs_p0     = !(run_p0 && (v_i >= V_ACTIVE + V_FP) && (v_i < V_ACTIVE + V_FP + V_SYNC));
    assign fs_p0     = run_p0 && (h_i == 0) && (v_i == 0);
    assign frame_end = run_p0 && (h_i == H_TOTAL - 1) && (v_i == V_TOTAL - 1);
    assign cell_p0   = vld_p0 ? ADDR_W'((v_i / CHAR_H) * COLS + h_i / CHAR_W) : '0;
    assign grow_p0   = GR_W'(v_i % CHAR_H);
    assign col_p0    = CW_W'(h_i % CHAR_W);

    // Stage 1: character buffer, read-first on a same-address write
    always_ff @(posedge clock_25) begin
        if (ram_we)
            mem[ram_waddr] <= ram_wdata;
        code_p1 <= mem[cell_p0];
    end

    always_ff @(posedge clock_25) begin
        grow_p1 <= grow_p0;
        col_p1  <= col_p0;
        cell_p1 <= cell_p0;
        col_p2  <= col_p1;
        cell_p2 <= cell_p1;
        col_p3  <= col_p2;
        cell_p3 <= cell_p2;
    end

    // Stage 1..3 control, stage 2 glyph address; font ROM answers during stage 3
    always_ff @(posedge clock_25) begin
        if (reset) begin
            run_p1     <= 1'b0;
            vld_p1     <= 1'b0;
            hs_p1      <= 1'b1;
            vs_p1      <= 1'b1;
            fs_p1      <= 1'b0;
            glyph_addr <= '0;
            vld_p2     <= 1'b0;
            hs_p2      <= 1'b1;
            vs_p2      <= 1'b1;
            fs_p2      <= 1'b0;
            vld_p3     <= 1'b0;
            hs_p3      <= 1'b1;
            vs_p3      <= 1'b1;
            fs_p3      <= 1'b0;
        end else begin
            run_p1     <= run_p0;
            vld_p1     <= vld_p0;
            hs_p1      <= hs_p0;
            vs_p1      <= vs_p0;
            fs_p1      <= fs_p0;
            glyph_addr <= run_p1 ? {code_p1, grow_p1} : '0;
            vld_p2     <= vld_p1;
            hs_p2      <= hs_p1;
            vs_p2      <= vs_p1;
            fs_p2      <= fs_p1;
            vld_p3     <= vld_p2;
            hs_p3      <= hs_p2;
            vs_p3      <= vs_p2;
            fs_p3      <= fs_p2;
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            blink_vis <= 1'b1;
            blink_cnt <= '0;
        end else if (frame_end) begin
            if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_vis <= !blink_vis;
            end else begin
                blink_cnt <= blink_cnt + BC_W'(1);
            end
        end
    end

    // Stage 4: pixel select and output registers
    assign cur_hit_p3 = cursor_en && blink_vis && (cell_p3 == cursor_addr);
    assign pix_p3     = glyph_data[CW_W'(CHAR_W - 1) - col_p3] ^ cur_hit_p3;
    assign rgb_p3     = shade(vld_p3, pix_p3);

    always_ff @(posedge clock_25) begin
        if (reset) begin
            red_out     <= 8'h00;
            green_out   <= 8'h00;
            blue_out    <= 8'h00;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            n_blank     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            red_out     <= rgb_p3[23:16];
            green_out   <= rgb_p3[15:8];
            blue_out    <= rgb_p3[7:0];
            hsync       <= hs_p3;
            vsync       <= vs_p3;
            n_blank     <= vld_p3;
            frame_start <= fs_p3;
        end
    end

endmodule
